// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

   localparam int unsigned CNT_W  = 4;
   localparam int unsigned WORD_W = 32;
   localparam int unsigned BE_W   = WORD_W / 8;

   typedef logic [CNT_W-1:0] cnt_t;

   typedef enum logic [1:0] {
      StIdle,
      StBusy,
      StResp
   } state_t;

   // Expand per-byte enables into a per-bit write mask.
   function automatic logic [WORD_W-1:0] be_to_mask(input logic [BE_W-1:0] be);
      logic [WORD_W-1:0] mask;
      mask = '0;
      for (int i = 0; i < BE_W; i++) begin
         mask[8*i +: 8] = {8{be[i]}};
      end
      return mask;
   endfunction

endpackage

// File: rtl/dmem_array.sv
// Byte-enabled word RAM: synchronous write, combinational read.
module dmem_array
   import dmem_pkg::*;
#(
   parameter int unsigned DEPTH = 1024,
   parameter int unsigned IDX_W = 10
) (
   input  logic              clk,
   input  logic              we,
   input  logic [BE_W-1:0]   be,
   input  logic [IDX_W-1:0]  index,
   input  logic [WORD_W-1:0] wdata,
   output logic [WORD_W-1:0] rdata
);

   logic [WORD_W-1:0] mem [DEPTH];
   logic [WORD_W-1:0] mask;

   assign mask  = be_to_mask(be);
   assign rdata = mem[index];

   // Merge enabled bytes of wdata into the addressed word.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[index] <= (mem[index] & ~mask) | (wdata & mask);
      end
   end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding request, LATENCY wait states, then a response.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int unsigned DEPTH   = 1024,
   parameter int unsigned LATENCY = 2,
   parameter int unsigned ADDR_W  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [WORD_W-1:0] req_wdata,
   input  logic [BE_W-1:0]   req_be,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [WORD_W-1:0] rsp_rdata,
   output logic              rsp_err
);

   localparam int unsigned       IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam cnt_t              LAT_CNT = cnt_t'(LATENCY);
   localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

   state_t              state_q, state_d;
   cnt_t                cnt_q, cnt_d;
   logic                cap_we_q, cap_we_d;
   logic [ADDR_W-1:0]   cap_addr_q, cap_addr_d;
   logic [WORD_W-1:0]   cap_wdata_q, cap_wdata_d;
   logic [BE_W-1:0]     cap_be_q, cap_be_d;
   logic [WORD_W-1:0]   rdata_q, rdata_d;
   logic                err_q, err_d;

   logic                access;
   logic                acc_we;
   logic [ADDR_W-1:0]   acc_addr;
   logic [WORD_W-1:0]   acc_wdata;
   logic [BE_W-1:0]     acc_be;
   logic [ADDR_W-3:0]   acc_idx;
   logic                acc_err;
   logic                mem_we;
   logic [WORD_W-1:0]   mem_rdata;

   assign req_ready = (state_q == StIdle);
   assign rsp_valid = (state_q == StResp);
   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q;

   // With zero latency the access happens on the acceptance edge, so it must use the live
   // request fields; otherwise it uses the captured copy.
   always_comb begin
      if (state_q == StIdle) begin
         acc_we    = req_we;
         acc_addr  = req_addr;
         acc_wdata = req_wdata;
         acc_be    = req_be;
      end else begin
         acc_we    = cap_we_q;
         acc_addr  = cap_addr_q;
         acc_wdata = cap_wdata_q;
         acc_be    = cap_be_q;
      end
      acc_idx = acc_addr[ADDR_W-1:2];
      acc_err = (acc_addr[1:0] != 2'b00) | ({2'b00, acc_idx} >= DEPTH_A);
      mem_we  = access & acc_we & ~acc_err;
   end

   dmem_array #(
      .DEPTH (DEPTH),
      .IDX_W (IDX_W)
   ) u_array (
      .clk   (clk),
      .we    (mem_we),
      .be    (acc_be),
      .index (acc_idx[IDX_W-1:0]),
      .wdata (acc_wdata),
      .rdata (mem_rdata)
   );

   // Next-state, wait counter, request capture and response data.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      cap_we_d    = cap_we_q;
      cap_addr_d  = cap_addr_q;
      cap_wdata_d = cap_wdata_q;
      cap_be_d    = cap_be_q;
      rdata_d     = rdata_q;
      err_d       = err_q;
      access      = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (req_valid) begin
               cap_we_d    = req_we;
               cap_addr_d  = req_addr;
               cap_wdata_d = req_wdata;
               cap_be_d    = req_be;
               cnt_d       = LAT_CNT;
               if (LATENCY == 0) begin
                  access  = 1'b1;
                  state_d = StResp;
               end else begin
                  state_d = StBusy;
               end
            end
         end
         StBusy: begin
            cnt_d = cnt_q - cnt_t'(1);
            if (cnt_q == cnt_t'(1)) begin
               access  = 1'b1;
               state_d = StResp;
            end
         end
         StResp: begin
            if (rsp_ready) begin
               state_d = StIdle;
               rdata_d = '0;
               err_d   = 1'b0;
            end
         end
         default: state_d = StIdle;
      endcase

      if (access) begin
         err_d   = acc_err;
         rdata_d = (acc_we | acc_err) ? '0 : mem_rdata;
      end
   end

   // State and datapath registers; the array itself is not reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         cap_we_q    <= 1'b0;
         cap_addr_q  <= '0;
         cap_wdata_q <= '0;
         cap_be_q    <= '0;
         rdata_q     <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         cap_we_q    <= cap_we_d;
         cap_addr_q  <= cap_addr_d;
         cap_wdata_q <= cap_wdata_d;
         cap_be_q    <= cap_be_d;
         rdata_q     <= rdata_d;
         err_q       <= err_d;
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench: a LATENCY=2 and a LATENCY=0 responder driven from one scoreboard.
module tb_dmem_responder;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        req_valid [2];
   logic        req_ready [2];
   logic        req_we    [2];
   logic [31:0] req_addr  [2];
   logic [31:0] req_wdata [2];
   logic [3:0]  req_be    [2];
   logic        rsp_valid [2];
   logic        rsp_ready [2];
   logic [31:0] rsp_rdata [2];
   logic        rsp_err   [2];

   int lat [2] = '{2, 0};

   dmem_responder #(
      .DEPTH   (1024),
      .LATENCY (2),
      .ADDR_W  (32)
   ) u_dut_lat2 (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid[0]),
      .req_ready (req_ready[0]),
      .req_we    (req_we[0]),
      .req_addr  (req_addr[0]),
      .req_wdata (req_wdata[0]),
      .req_be    (req_be[0]),
      .rsp_valid (rsp_valid[0]),
      .rsp_ready (rsp_ready[0]),
      .rsp_rdata (rsp_rdata[0]),
      .rsp_err   (rsp_err[0])
   );

   dmem_responder #(
      .DEPTH   (1024),
      .LATENCY (0),
      .ADDR_W  (32)
   ) u_dut_lat0 (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid[1]),
      .req_ready (req_ready[1]),
      .req_we    (req_we[1]),
      .req_addr  (req_addr[1]),
      .req_wdata (req_wdata[1]),
      .req_be    (req_be[1]),
      .rsp_valid (rsp_valid[1]),
      .rsp_ready (rsp_ready[1]),
      .rsp_rdata (rsp_rdata[1]),
      .rsp_err   (rsp_err[1])
   );

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   exp_t sb_q [$];
   int   n_checks = 0;
   int   n_errors = 0;
   int   cyc      = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic drive_req(input int d, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] be);
      req_valid[d] = 1'b1;
      req_we[d]    = we;
      req_addr[d]  = addr;
      req_wdata[d] = wdata;
      req_be[d]    = be;
   endtask

   // One full transaction; optionally stall the response and pre-assert a load of 0x10.
   task automatic txn(input int d, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] be,
                      input logic [31:0] exp_rdata, input logic exp_err,
                      input int hold, input bit pre);
      exp_t e;
      int   n;
      int   e0;
      sb_q.push_back('{rdata: exp_rdata, err: exp_err});
      @(negedge clk);
      drive_req(d, we, addr, wdata, be);
      n = 0;
      while (!req_ready[d] && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) check_eq("req_accept_timeout", 32'(n), 32'd0);
      @(posedge clk);
      #1;
      e0 = cyc;
      req_valid[d] = 1'b0;
      check_eq("req_ready_drop", 32'(req_ready[d]), 32'd0);
      n = 0;
      @(negedge clk);
      while (!rsp_valid[d] && n < 50) begin
         @(negedge clk);
         n++;
      end
      check_eq("rsp_latency", 32'(cyc - e0), 32'(lat[d]));
      if (sb_q.size() == 0) begin
         check_eq("sb_underflow", 32'(sb_q.size()), 32'd1);
         e = '0;
      end else begin
         e = sb_q.pop_front();
      end
      check_eq("rsp_rdata", rsp_rdata[d], e.rdata);
      check_eq("rsp_err", 32'(rsp_err[d]), 32'(e.err));
      for (int h = 0; h < hold; h++) begin
         if (pre) drive_req(d, 1'b0, 32'h10, 32'h0, 4'h0);
         check_eq("hold_valid", 32'(rsp_valid[d]), 32'd1);
         check_eq("hold_rdata", rsp_rdata[d], e.rdata);
         check_eq("hold_req_ready", 32'(req_ready[d]), 32'd0);
         @(negedge clk);
      end
      rsp_ready[d] = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready[d] = 1'b0;
      check_eq("post_rsp_valid", 32'(rsp_valid[d]), 32'd0);
      check_eq("post_rsp_rdata", rsp_rdata[d], 32'd0);
      check_eq("post_rsp_err", 32'(rsp_err[d]), 32'd0);
      check_eq("post_req_ready", 32'(req_ready[d]), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int   nresp;
      exp_t e;
      rst = 1'b0;
      for (int d = 0; d < 2; d++) begin
         req_valid[d] = 1'b0;
         req_we[d]    = 1'b0;
         req_addr[d]  = '0;
         req_wdata[d] = '0;
         req_be[d]    = '0;
         rsp_ready[d] = 1'b0;
      end
      repeat (2) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         check_eq("reset_req_ready", 32'(req_ready[d]), 32'd1);
         check_eq("reset_rsp_valid", 32'(rsp_valid[d]), 32'd0);
         check_eq("reset_rsp_rdata", rsp_rdata[d], 32'd0);
         check_eq("reset_rsp_err", 32'(rsp_err[d]), 32'd0);
      end
      rst = 1'b1;

      // LATENCY=2: full and partial stores, loads back
      txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0, 0, 1'b0);
      txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, 0, 1'b0);
      txn(0, 1'b1, 32'h10, 32'h000000AA, 4'h1, 32'h0, 1'b0, 0, 1'b0);
      txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEAA, 1'b0, 0, 1'b0);

      // Errors: misaligned load, out-of-range store (would alias word 0 if not gated)
      txn(0, 1'b1, 32'h0, 32'h12345678, 4'hF, 32'h0, 1'b0, 0, 1'b0);
      txn(0, 1'b0, 32'h12, 32'h0, 4'h0, 32'h0, 1'b1, 0, 1'b0);
      txn(0, 1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1, 0, 1'b0);
      txn(0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h12345678, 1'b0, 0, 1'b0);
      txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEAA, 1'b0, 0, 1'b0);

      // be=0000 store is an acknowledged no-op
      txn(0, 1'b1, 32'h10, 32'h55555555, 4'h0, 32'h0, 1'b0, 0, 1'b0);
      txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEAA, 1'b0, 0, 1'b0);

      // Stalled response with a request waiting behind it
      txn(0, 1'b1, 32'h14, 32'h0BADF00D, 4'hF, 32'h0, 1'b0, 0, 1'b0);
      txn(0, 1'b0, 32'h14, 32'h0, 4'h0, 32'h0BADF00D, 1'b0, 5, 1'b1);
      txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEAA, 1'b0, 0, 1'b0);

      // Reset during BUSY of a store discards it
      txn(0, 1'b1, 32'h20, 32'h11111111, 4'hF, 32'h0, 1'b0, 0, 1'b0);
      @(negedge clk);
      drive_req(0, 1'b1, 32'h20, 32'h22222222, 4'hF);
      @(posedge clk);
      #1;
      req_valid[0] = 1'b0;
      check_eq("busy_req_ready", 32'(req_ready[0]), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_eq("async_rst_req_ready", 32'(req_ready[0]), 32'd1);
      check_eq("async_rst_rsp_valid", 32'(rsp_valid[0]), 32'd0);
      check_eq("async_rst_rsp_rdata", rsp_rdata[0], 32'd0);
      check_eq("async_rst_rsp_err", 32'(rsp_err[0]), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      txn(0, 1'b0, 32'h20, 32'h0, 4'h0, 32'h11111111, 1'b0, 0, 1'b0);

      // LATENCY=0 build
      txn(1, 1'b1, 32'h0, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0, 0, 1'b0);
      txn(1, 1'b0, 32'h0, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0, 0, 1'b0);

      // Back-to-back loads with rsp_ready held: one response per two cycles
      for (int i = 0; i < 5; i++) sb_q.push_back('{rdata: 32'hCAFEF00D, err: 1'b0});
      @(negedge clk);
      rsp_ready[1] = 1'b1;
      drive_req(1, 1'b0, 32'h0, 32'h0, 4'h0);
      nresp = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (rsp_valid[1]) begin
            if (sb_q.size() == 0) begin
               check_eq("b2b_sb_underflow", 32'(sb_q.size()), 32'd1);
            end else begin
               e = sb_q.pop_front();
               check_eq("b2b_rdata", rsp_rdata[1], e.rdata);
               check_eq("b2b_err", 32'(rsp_err[1]), 32'(e.err));
            end
            nresp++;
         end
      end
      req_valid[1] = 1'b0;
      rsp_ready[1] = 1'b0;
      check_eq("b2b_count", 32'(nresp), 32'd5);
      check_eq("sb_drained", 32'(sb_q.size()), 32'd0);

      repeat (2) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
